// File: rtl/hex_seg_pkg.sv
// Shared constants and types for the 7-segment read-back checker.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: active-low segment patterns {g,f,e,d,c,b,a} for hex digits 0..F,
//           the all-off blank pattern, and the output-holding FSM state type.
package hex_seg_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/hex_seg_reader_seg7_to_nibble.sv
// Decodes one active-low 7-segment pattern back to its hex nibble.
// Latency: combinational.
// Backpressure: none.
// Ports: seg_n[6:0] in ({g..a}, 0 = lit); hit out (pattern is legal); nibble[3:0] out.
// Config macro: HEX_SEG_READER_BLANK_EN -- when defined, the all-off pattern is a
//               legal blank digit decoded as nibble 0; otherwise it is illegal.
module seg7_to_nibble
   import hex_seg_pkg::*;
(
   input  logic [6:0] seg_n,
   output logic       hit,
   output logic [3:0] nibble
);

`ifdef HEX_SEG_READER_BLANK_EN
   localparam logic BLANK_OK = 1'b1;
`else
   localparam logic BLANK_OK = 1'b0;
`endif

   always_comb begin
      hit    = 1'b1;
      nibble = 4'h0;
      case (seg_n)
         SEG_0:   nibble = 4'h0;
         SEG_1:   nibble = 4'h1;
         SEG_2:   nibble = 4'h2;
         SEG_3:   nibble = 4'h3;
         SEG_4:   nibble = 4'h4;
         SEG_5:   nibble = 4'h5;
         SEG_6:   nibble = 4'h6;
         SEG_7:   nibble = 4'h7;
         SEG_8:   nibble = 4'h8;
         SEG_9:   nibble = 4'h9;
         SEG_A:   nibble = 4'hA;
         SEG_B:   nibble = 4'hB;
         SEG_C:   nibble = 4'hC;
         SEG_D:   nibble = 4'hD;
         SEG_E:   nibble = 4'hE;
         SEG_F:   nibble = 4'hF;
         default: hit    = BLANK_OK && (seg_n == SEG_BLANK);
      endcase
   end

endmodule

// File: rtl/hex_seg_reader.sv
// Recovers a multi-digit hex word from a scanned active-low 7-segment bus.
// Latency: word presented 2 cycles after the final digit's acceptance cycle.
// Backpressure: value held while value_valid && !value_ready; a word completing
//               then is dropped and flags overrun.
// Ports: clock, resetn (async assert, synchronised release); seg_n/seg_idx/seg_valid
//        sample input; value/value_valid/value_ready output handshake;
//        err (sticky, stable illegal pattern), overrun (sticky, word dropped).
// Config macro: HEX_SEG_READER_BLANK_EN (see seg7_to_nibble).
module hex_seg_reader
   import hex_seg_pkg::*;
#(
   parameter int DIGITS        = 3,
   parameter int IDXW          = 2,
   parameter int STABLE_CYCLES = 4
)
(
   input  logic                  clock,
   input  logic                  resetn,
   input  logic [6:0]            seg_n,
   input  logic [IDXW-1:0]       seg_idx,
   input  logic                  seg_valid,
   output logic [4*DIGITS-1:0]   value,
   output logic                  value_valid,
   input  logic                  value_ready,
   output logic                  err,
   output logic                  overrun
);

   localparam int               W       = 4 * DIGITS;
   localparam int               CW      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CW-1:0]    CNT_MAX = CW'(STABLE_CYCLES - 1);
   localparam logic [IDXW:0]    DIG_LIM = (IDXW+1)'(DIGITS);

   // Reset: assertion reaches every flop at once, release is re-timed to clock.
   logic rst_meta_q;
   logic rst_n;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rst_meta_q <= 1'b0;
         rst_n      <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         rst_n      <= rst_meta_q;
      end
   end

   // ---------------- glitch filter ----------------
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [6+IDXW:0]   prev_q, prev_d;
   logic              accept;
   logic              take;
   logic              same;

   // Out-of-range digit positions are invisible to the filter.
   assign take = seg_valid && ({1'b0, seg_idx} < DIG_LIM);
   assign same = ({seg_n, seg_idx} == prev_q);

   always_comb begin
      cnt_d  = cnt_q;
      prev_d = prev_q;
      accept = 1'b0;
      if (take) begin
         if (same) begin
            // Saturating, so a long stable run raises only one acceptance.
            if (cnt_q != CNT_MAX) begin
               cnt_d  = cnt_q + 1'b1;
               accept = (cnt_d == CNT_MAX);
            end
         end else begin
            cnt_d  = '0;
            prev_d = {seg_n, seg_idx};
            // A single required sample accepts on the first sight of a new pattern.
            accept = (CNT_MAX == '0);
         end
      end
   end

   // ---------------- decode, slots and mask ----------------
   logic              hit;
   logic [3:0]        nibble;
   logic [W-1:0]      slot_q, slot_d;
   logic [DIGITS-1:0] mask_q, mask_d;
   logic              err_q, err_d;
   logic              complete;

   seg7_to_nibble u_dec (
      .seg_n  (seg_n),
      .hit    (hit),
      .nibble (nibble)
   );

   assign complete = &mask_q;

   always_comb begin
      slot_d = slot_q;
      mask_d = complete ? '0 : mask_q;
      err_d  = err_q;
      if (accept) begin
         if (hit) begin
            for (int k = 0; k < DIGITS; k++) begin
               if (int'(seg_idx) == k) begin
                  slot_d[4*k +: 4] = nibble;
                  mask_d[k]        = 1'b1;
               end
            end
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // ---------------- output holding FSM ----------------
   state_t            st_q, st_d;
   logic [W-1:0]      value_q, value_d;
   logic              overrun_q, overrun_d;

   always_comb begin
      st_d      = st_q;
      value_d   = value_q;
      overrun_d = overrun_q;
      case (st_q)
         ST_EMPTY: begin
            if (complete) begin
               st_d    = ST_FULL;
               value_d = slot_q;
            end
         end
         ST_FULL: begin
            if (complete && value_ready) begin
               value_d = slot_q;
            end else if (complete) begin
               overrun_d = 1'b1;
            end else if (value_ready) begin
               st_d = ST_EMPTY;
            end
         end
         default: st_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         prev_q    <= '0;
         slot_q    <= '0;
         mask_q    <= '0;
         err_q     <= 1'b0;
         st_q      <= ST_EMPTY;
         value_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         prev_q    <= prev_d;
         slot_q    <= slot_d;
         mask_q    <= mask_d;
         err_q     <= err_d;
         st_q      <= st_d;
         value_q   <= value_d;
         overrun_q <= overrun_d;
      end
   end

   assign value       = value_q;
   assign value_valid = (st_q == ST_FULL);
   assign err         = err_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_hex_seg_reader.sv
// Directed bench for hex_seg_reader (DIGITS=3, STABLE_CYCLES=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_hex_seg_reader;

   logic        clock = 1'b0;
   logic        resetn;
   logic [6:0]  seg_n;
   logic [1:0]  seg_idx;
   logic        seg_valid;
   logic [11:0] value;
   logic        value_valid;
   logic        value_ready;
   logic        err;
   logic        overrun;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   hex_seg_reader #(
      .DIGITS        (3),
      .IDXW          (2),
      .STABLE_CYCLES (4)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .seg_n       (seg_n),
      .seg_idx     (seg_idx),
      .seg_valid   (seg_valid),
      .value       (value),
      .value_valid (value_valid),
      .value_ready (value_ready),
      .err         (err),
      .overrun     (overrun)
   );

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check12(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   // n consecutive valid samples, then one idle cycle with seg_valid low.
   task automatic drive(input logic [6:0] s, input logic [1:0] i, input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clock);
         seg_n     = s;
         seg_idx   = i;
         seg_valid = 1'b1;
      end
      @(negedge clock);
      seg_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      resetn = 1'b0;
      idle(2);
      resetn = 1'b1;
      idle(3);
   endtask

   // Called right after the final digit's drive: not yet valid, valid one cycle later.
   task automatic expect_word(input string tag, input logic [11:0] exp);
      check1({tag, "_lat"}, value_valid, 1'b0);
      @(negedge clock);
      check1({tag, "_vld"}, value_valid, 1'b1);
      check12({tag, "_val"}, value, exp);
   endtask

   initial begin
      resetn      = 1'b0;
      seg_n       = 7'h00;
      seg_idx     = 2'd0;
      seg_valid   = 1'b0;
      value_ready = 1'b1;
      #1;
      check12("rst_value", value, 12'h000);
      check1("rst_vld", value_valid, 1'b0);
      check1("rst_err", err, 1'b0);
      check1("rst_ovr", overrun, 1'b0);
      idle(2);
      resetn = 1'b1;
      idle(3);

      // 1: basic word 0x125, one-cycle valid pulse with ready high
      drive(7'h12, 2'd0, 4);
      drive(7'h24, 2'd1, 4);
      drive(7'h79, 2'd2, 4);
      expect_word("t1", 12'h125);
      @(negedge clock);
      check1("t1_pulse", value_valid, 1'b0);
      check1("t1_err", err, 1'b0);
      check1("t1_ovr", overrun, 1'b0);

      // 2: toggling digit never captures; ready held low so a stray word would stick
      value_ready = 1'b0;
      drive(7'h40, 2'd1, 4);
      drive(7'h40, 2'd2, 4);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         seg_n     = (i % 2 == 0) ? 7'h79 : 7'h40;
         seg_idx   = 2'd0;
         seg_valid = 1'b1;
      end
      @(negedge clock);
      seg_valid = 1'b0;
      check1("t2_nocap_a", value_valid, 1'b0);
      idle(2);
      check1("t2_nocap_b", value_valid, 1'b0);
      drive(7'h79, 2'd0, 4);
      expect_word("t2", 12'h001);
      value_ready = 1'b1;
      @(negedge clock);
      check1("t2_drain", value_valid, 1'b0);

      // 3: blank pattern on idx1
      drive(7'h7F, 2'd1, 4);
`ifdef HEX_SEG_READER_BLANK_EN
      check1("t3_err_blank", err, 1'b0);
      drive(7'h40, 2'd0, 4);
      drive(7'h40, 2'd2, 4);
      expect_word("t3", 12'h000);
      check1("t3_err_end", err, 1'b0);
`else
      check1("t3_err_blank", err, 1'b1);
      drive(7'h40, 2'd0, 4);
      drive(7'h40, 2'd2, 4);
      check1("t3_noword_a", value_valid, 1'b0);
      idle(1);
      check1("t3_noword_b", value_valid, 1'b0);
      idle(1);
      check1("t3_noword_c", value_valid, 1'b0);
      check1("t3_err_end", err, 1'b1);
`endif
      do_reset();
      check1("t3_err_rst", err, 1'b0);

      // 4: overrun while holding 0x0AB
      value_ready = 1'b0;
      drive(7'h03, 2'd0, 4);
      drive(7'h08, 2'd1, 4);
      drive(7'h40, 2'd2, 4);
      expect_word("t4a", 12'h0AB);
      check1("t4a_ovr", overrun, 1'b0);
      drive(7'h21, 2'd0, 4);
      drive(7'h46, 2'd1, 4);
      drive(7'h40, 2'd2, 4);
      idle(1);
      check1("t4_ovr", overrun, 1'b1);
      check1("t4_hold_vld", value_valid, 1'b1);
      check12("t4_hold_val", value, 12'h0AB);
      value_ready = 1'b1;
      @(negedge clock);
      check1("t4_drain", value_valid, 1'b0);
      check12("t4_val_kept", value, 12'h0AB);

      // 5: reset mid-word discards the partial mask
      drive(7'h40, 2'd0, 4);
      drive(7'h40, 2'd1, 4);
      @(negedge clock);
      seg_n     = 7'h40;
      seg_idx   = 2'd2;
      seg_valid = 1'b1;
      idle(2);
      #1;
      resetn    = 1'b0;
      seg_valid = 1'b0;
      #1;
      check12("t5_rst_val", value, 12'h000);
      check1("t5_rst_vld", value_valid, 1'b0);
      check1("t5_rst_err", err, 1'b0);
      check1("t5_rst_ovr", overrun, 1'b0);
      idle(2);
      resetn = 1'b1;
      idle(3);
      drive(7'h40, 2'd2, 4);
      check1("t5_noword_a", value_valid, 1'b0);
      idle(1);
      check1("t5_noword_b", value_valid, 1'b0);
      idle(1);
      check1("t5_noword_c", value_valid, 1'b0);

      // 6: out-of-range index ignored; gapped run still captures
      value_ready = 1'b0;
      drive(7'h40, 2'd3, 8);
      check1("t6_idx3_err", err, 1'b0);
      check1("t6_idx3_vld", value_valid, 1'b0);
      @(negedge clock); seg_n = 7'h79; seg_idx = 2'd0; seg_valid = 1'b1;
      @(negedge clock); seg_valid = 1'b0;
      @(negedge clock); seg_valid = 1'b1;
      @(negedge clock); seg_valid = 1'b0;
      @(negedge clock); seg_valid = 1'b1;
      @(negedge clock);
      @(negedge clock); seg_valid = 1'b0;
      drive(7'h24, 2'd1, 4);
      expect_word("t6", 12'h021);
      check1("t6_err", err, 1'b0);

      // reset while FULL drops value_valid without waiting for a clock
      #1;
      resetn = 1'b0;
      #1;
      check1("t6_async_vld", value_valid, 1'b0);
      check12("t6_async_val", value, 12'h000);
      idle(2);
      resetn = 1'b1;
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
